// File: rtl/uart_pkg.sv
// Shared UART constants: parity modes, FSM state encodings and bit-timing helpers.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Rounded clocks-per-bit.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; push while full
// is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dat_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != (AW+1)'(DEPTH)) || do_pop);
  assign dat_o   = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= dat_i;
  end

endmodule

// File: rtl/uart_fifo.sv
// Full-duplex UART with TX and RX FIFOs; TX frames stream back-to-back while the TX FIFO
// holds data, received characters appear one cycle after the stop sample.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY     = 0
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          RxD,
  output logic                          TxD,
  input  logic                          readRX,
  output logic                          charReady,
  output logic [DATA_BITS-1:0]          RXchar,
  input  logic                          writeTX,
  input  logic [DATA_BITS-1:0]          TXchar,
  output logic                          TXempty,
  output logic                          TXidle,
  output logic [$clog2(FIFO_DEPTH):0]   RXcount,
  output logic [2:0]                    errFlags,
  input  logic                          clrErr
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int CW  = cnt_width(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);
  localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);

  logic [AW:0]            tx_cnt, rx_cnt;
  logic [DATA_BITS-1:0]   tx_head;
  logic                   tx_empty, tx_full, rx_full, tx_pop, tx_load, rx_push;

  logic [2:0]             tx_st_q, tx_st_d, rx_st_q, rx_st_d;
  logic [CW-1:0]          tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [3:0]             tx_idx_q, tx_idx_d, rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic                   tx_par_q, tx_par_d, rx_par_q, rx_par_d, tx_q, tx_d;
  logic [1:0]             sync_q;
  logic                   rx_prev_q, rx_s, tx_end, rx_end, rx_done, par_ok, rx_good;
  logic [2:0]             err_q, err_d;

  assign tx_empty  = (tx_cnt == '0);
  assign tx_full   = (tx_cnt == (AW+1)'(FIFO_DEPTH));
  assign rx_full   = (rx_cnt == (AW+1)'(FIFO_DEPTH));
  assign TxD       = tx_q;
  assign TXempty   = !tx_full;
  assign TXidle    = (tx_st_q == ST_IDLE) && tx_empty;
  assign charReady = (rx_cnt != '0);
  assign RXcount   = rx_cnt;
  assign errFlags  = err_q;

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i(Clock), .rst_i(Reset), .push_i(writeTX && !tx_full), .dat_i(TXchar),
    .pop_i(tx_pop), .dat_o(tx_head), .count_o(tx_cnt)
  );

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i(Clock), .rst_i(Reset), .push_i(rx_push), .dat_i(rx_shift_q),
    .pop_i(readRX), .dat_o(RXchar), .count_o(rx_cnt)
  );

  assign tx_end = (tx_cnt_q == BIT_END);

  always_comb begin
    tx_st_d    = tx_st_q;
    tx_cnt_d   = tx_end ? '0 : tx_cnt_q + 1'b1;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    tx_load    = 1'b0;
    case (tx_st_q)
      ST_IDLE: begin
        tx_cnt_d = '0;
        tx_d     = 1'b1;
        tx_load  = !tx_empty;
      end
      ST_START: if (tx_end) begin
        tx_st_d  = ST_DATA;
        tx_idx_d = '0;
        tx_d     = tx_shift_q[0];
      end
      ST_DATA: if (tx_end) begin
        if (tx_idx_q == LAST_BIT) begin
          tx_st_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          tx_d    = (PARITY != PAR_NONE) ? tx_par_q : 1'b1;
        end else begin
          tx_idx_d   = tx_idx_q + 1'b1;
          tx_shift_d = tx_shift_q >> 1;
          tx_d       = tx_shift_q[1];
        end
      end
      ST_PARITY: if (tx_end) begin
        tx_st_d = ST_STOP;
        tx_d    = 1'b1;
      end
      ST_STOP: if (tx_end) begin
        tx_st_d = ST_IDLE;
        tx_load = !tx_empty;
      end
      default: tx_st_d = ST_IDLE;
    endcase
    // Loading from STOP skips IDLE so consecutive frames have no gap.
    tx_pop = tx_load;
    if (tx_load) begin
      tx_st_d    = ST_START;
      tx_cnt_d   = '0;
      tx_shift_d = tx_head;
      tx_par_d   = (PARITY == PAR_ODD) ? ~^tx_head : ^tx_head;
      tx_d       = 1'b0;
    end
  end

  assign rx_s   = sync_q[1];
  assign rx_end = (rx_cnt_q == BIT_END);

  always_comb begin
    rx_st_d    = rx_st_q;
    rx_cnt_d   = rx_end ? '0 : rx_cnt_q + 1'b1;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    case (rx_st_q)
      ST_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s) rx_st_d = ST_START;
      end
      ST_START: if (rx_cnt_q == HALF_END) begin
        rx_cnt_d = '0;
        rx_idx_d = '0;
        rx_st_d  = rx_s ? ST_IDLE : ST_DATA;
      end
      ST_DATA: if (rx_end) begin
        rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
        if (rx_idx_q == LAST_BIT) rx_st_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
        else                      rx_idx_d = rx_idx_q + 1'b1;
      end
      ST_PARITY: if (rx_end) begin
        rx_par_d = rx_s;
        rx_st_d  = ST_STOP;
      end
      ST_STOP: if (rx_end) rx_st_d = ST_IDLE;
      default: rx_st_d = ST_IDLE;
    endcase
  end

  assign rx_done = (rx_st_q == ST_STOP) && rx_end;
  assign par_ok  = (PARITY == PAR_NONE) || ((^{rx_shift_q, rx_par_q}) == (PARITY == PAR_ODD));
  assign rx_good = rx_done && rx_s && par_ok;
  assign rx_push = rx_good && (!rx_full || readRX);

  // A fresh error in the clearing cycle still sticks.
  always_comb begin
    err_d    = clrErr ? 3'b000 : err_q;
    err_d[2] = err_d[2] | (rx_done && rx_s && !par_ok);
    err_d[1] = err_d[1] | (rx_done && !rx_s);
    err_d[0] = err_d[0] | (rx_good && rx_full && !readRX);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      tx_st_q    <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      rx_st_q    <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      sync_q     <= 2'b11;
      rx_prev_q  <= 1'b1;
      err_q      <= 3'b000;
    end else begin
      tx_st_q    <= tx_st_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      sync_q     <= {sync_q[0], RxD};
      rx_prev_q  <= sync_q[1];
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_fifo.sv
// Bench for uart_fifo at 16 clocks per bit: framing, loopback, FIFO limits, RX errors, reset.
module tb_uart_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       loop_en, rxd_drv, readrx, wtx, clr;
  logic [7:0] txchar;
  logic       txd, cr, te, ti;
  logic [7:0] rxchar;
  logic [4:0] rcount;
  logic [2:0] err;
  wire        rxd = loop_en ? txd : rxd_drv;

  logic       rxd_p, readrx_p, wtx_p, clr_p;
  logic [7:0] txchar_p;
  logic       txd_p, cr_p, te_p, ti_p;
  logic [7:0] rxchar_p;
  logic [4:0] rcount_p;
  logic [2:0] err_p;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  uart_fifo #(.CLK_HZ(160), .BAUD(10), .DATA_BITS(8), .FIFO_DEPTH(16), .PARITY(0)) dut (
    .Clock(clk), .Reset(rst), .RxD(rxd), .TxD(txd), .readRX(readrx), .charReady(cr),
    .RXchar(rxchar), .writeTX(wtx), .TXchar(txchar), .TXempty(te), .TXidle(ti),
    .RXcount(rcount), .errFlags(err), .clrErr(clr)
  );

  uart_fifo #(.CLK_HZ(160), .BAUD(10), .DATA_BITS(8), .FIFO_DEPTH(16), .PARITY(1)) dut_p (
    .Clock(clk), .Reset(rst), .RxD(rxd_p), .TxD(txd_p), .readRX(readrx_p), .charReady(cr_p),
    .RXchar(rxchar_p), .writeTX(wtx_p), .TXchar(txchar_p), .TXempty(te_p), .TXidle(ti_p),
    .RXcount(rcount_p), .errFlags(err_p), .clrErr(clr_p)
  );

  task automatic tx_write(input logic [7:0] d);
    wtx = 1'b1;
    txchar = d;
    @(negedge clk);
    wtx = 1'b0;
  endtask

  task automatic rx_frame(input bit sel, input logic [7:0] d, input bit par_en,
                          input bit par_b, input bit stop_b);
    logic [10:0] bits;
    int n;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    n = 9;
    if (par_en) begin
      bits[9] = par_b;
      n = 10;
    end
    bits[n] = stop_b;
    n++;
    for (int i = 0; i < n; i++) begin
      if (sel) rxd_p = bits[i]; else rxd_drv = bits[i];
      repeat (16) @(negedge clk);
    end
    if (sel) rxd_p = 1'b1; else rxd_drv = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (txd !== 1'b1)    begin miscompares++; $display("FAIL reset_txd: got %b want 1", txd); end
    vectors++; if (cr !== 1'b0)     begin miscompares++; $display("FAIL reset_charReady: got %b want 0", cr); end
    vectors++; if (te !== 1'b1)     begin miscompares++; $display("FAIL reset_TXempty: got %b want 1", te); end
    vectors++; if (ti !== 1'b1)     begin miscompares++; $display("FAIL reset_TXidle: got %b want 1", ti); end
    vectors++; if (rcount !== 5'd0) begin miscompares++; $display("FAIL reset_RXcount: got %0d want 0", rcount); end
    vectors++; if (err !== 3'b000)  begin miscompares++; $display("FAIL reset_errFlags: got %b want 000", err); end
  endtask

  task automatic test_tx_frame;
    logic [7:0] d;
    logic       eb;
    bit         found;
    int         idx;
    d = 8'h55;
    found = 0;
    tx_write(d);
    for (int c = 0; c < 4 && !found; c++) begin
      @(negedge clk);
      if (txd === 1'b0) found = 1;
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL tx_start_edge: got no start bit, want TxD low within 4 cycles"); end
    idx = 0;
    for (int k = 0; k < 10; k++) begin
      while (idx < 8 + 16 * k) begin @(negedge clk); idx++; end
      eb = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : d[k-1];
      vectors++; if (txd !== eb) begin miscompares++; $display("FAIL tx_bit%0d: got %b want %b", k, txd, eb); end
    end
    while (idx < 159) begin @(negedge clk); idx++; end
    vectors++; if (ti !== 1'b0) begin miscompares++; $display("FAIL tx_idle_early: got %b want 0 at cycle 159", ti); end
    @(negedge clk);
    vectors++; if (ti !== 1'b1) begin miscompares++; $display("FAIL tx_idle_end: got %b want 1 at cycle 160", ti); end
  endtask

  task automatic test_loopback;
    logic [7:0] e;
    int got;
    loop_en = 1'b1;
    got = 0;
    tx_write(8'h00); exp_q.push_back(8'h00);
    tx_write(8'hFF); exp_q.push_back(8'hFF);
    tx_write(8'hA5); exp_q.push_back(8'hA5);
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      readrx = 1'b0;
      if (cr) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL loop_extra: got %h want nothing", rxchar);
        end else begin
          e = exp_q.pop_front(); got++;
          if (rxchar !== e) begin miscompares++; $display("FAIL loop_char: got %h want %h", rxchar, e); end
        end
        readrx = 1'b1;
      end
    end
    @(negedge clk); readrx = 1'b0;
    vectors++; if (got != 3)       begin miscompares++; $display("FAIL loop_count: got %0d want 3", got); end
    vectors++; if (err !== 3'b000) begin miscompares++; $display("FAIL loop_err: got %b want 000", err); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back_full;
    logic [7:0] e;
    int got;
    got = 0;
    for (int i = 0; i < 17; i++) begin
      tx_write(8'h10 + 8'(i));
      exp_q.push_back(8'h10 + 8'(i));
    end
    vectors++; if (te !== 1'b0) begin miscompares++; $display("FAIL tx_full_flag: got %b want 0", te); end
    tx_write(8'hEE);
    vectors++; if (te !== 1'b0) begin miscompares++; $display("FAIL tx_full_hold: got %b want 0", te); end
    for (int c = 0; c < 3100; c++) begin
      @(negedge clk);
      readrx = 1'b0;
      if (cr) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL full_extra: got %h want nothing", rxchar);
        end else begin
          e = exp_q.pop_front(); got++;
          if (rxchar !== e) begin miscompares++; $display("FAIL full_char: got %h want %h", rxchar, e); end
        end
        readrx = 1'b1;
      end
    end
    @(negedge clk); readrx = 1'b0;
    vectors++; if (got != 17)      begin miscompares++; $display("FAIL full_count: got %0d want 17", got); end
    vectors++; if (ti !== 1'b1)    begin miscompares++; $display("FAIL full_idle: got %b want 1", ti); end
    vectors++; if (err !== 3'b000) begin miscompares++; $display("FAIL full_err: got %b want 000", err); end
    exp_q.delete();
    loop_en = 1'b0;
  endtask

  task automatic test_rx_overrun;
    logic [7:0] e;
    int got;
    got = 0;
    for (int i = 0; i < 17; i++) begin
      rx_frame(0, 8'hC0 + 8'(i), 0, 0, 1);
      if (i < 16) exp_q.push_back(8'hC0 + 8'(i));
    end
    repeat (4) @(negedge clk);
    vectors++; if (rcount !== 5'd16) begin miscompares++; $display("FAIL ovr_count: got %0d want 16", rcount); end
    vectors++; if (err !== 3'b001)   begin miscompares++; $display("FAIL ovr_flag: got %b want 001", err); end
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    vectors++; if (err !== 3'b000)   begin miscompares++; $display("FAIL ovr_clear: got %b want 000", err); end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      readrx = 1'b0;
      if (cr) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL ovr_extra: got %h want nothing", rxchar);
        end else begin
          e = exp_q.pop_front(); got++;
          if (rxchar !== e) begin miscompares++; $display("FAIL ovr_char: got %h want %h", rxchar, e); end
        end
        readrx = 1'b1;
      end
    end
    @(negedge clk); readrx = 1'b0;
    vectors++; if (got != 16) begin miscompares++; $display("FAIL ovr_drained: got %0d want 16", got); end
    exp_q.delete();
  endtask

  task automatic test_rx_errors;
    rxd_drv = 1'b0;
    repeat (5) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (40) @(negedge clk);
    vectors++; if (cr !== 1'b0)    begin miscompares++; $display("FAIL glitch_char: got %b want 0", cr); end
    vectors++; if (err !== 3'b000) begin miscompares++; $display("FAIL glitch_err: got %b want 000", err); end
    rx_frame(0, 8'h3C, 0, 0, 0);
    repeat (20) @(negedge clk);
    vectors++; if (err !== 3'b010) begin miscompares++; $display("FAIL frame_err: got %b want 010", err); end
    vectors++; if (cr !== 1'b0)    begin miscompares++; $display("FAIL frame_drop: got %b want 0", cr); end
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    // 0x5A has four ones, so even parity bit is 0.
    exp_q.push_back(8'h5A);
    rx_frame(1, 8'h5A, 1, 0, 1);
    repeat (4) @(negedge clk);
    vectors++; if (cr_p !== 1'b1) begin miscompares++; $display("FAIL par_good_ready: got %b want 1", cr_p); end
    vectors++; if (rxchar_p !== exp_q[0]) begin miscompares++; $display("FAIL par_good_char: got %h want %h", rxchar_p, exp_q[0]); end
    void'(exp_q.pop_front());
    vectors++; if (err_p !== 3'b000) begin miscompares++; $display("FAIL par_good_err: got %b want 000", err_p); end
    readrx_p = 1'b1; @(negedge clk); readrx_p = 1'b0;
    rx_frame(1, 8'h5A, 1, 1, 1);
    repeat (4) @(negedge clk);
    vectors++; if (err_p !== 3'b100) begin miscompares++; $display("FAIL par_bad_err: got %b want 100", err_p); end
    vectors++; if (cr_p !== 1'b0)    begin miscompares++; $display("FAIL par_bad_drop: got %b want 0", cr_p); end
  endtask

  task automatic test_reset_mid_tx;
    logic [7:0] e;
    bit found;
    int got;
    rx_frame(0, 8'h77, 0, 0, 1);
    repeat (4) @(negedge clk);
    vectors++; if (cr !== 1'b1) begin miscompares++; $display("FAIL pre_rst_rx: got %b want 1", cr); end
    tx_write(8'hA5);
    tx_write(8'h11);
    found = 0;
    for (int c = 0; c < 4 && !found; c++) begin
      @(negedge clk);
      if (txd === 1'b0) found = 1;
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL rst_start_edge: got no start bit, want TxD low"); end
    repeat (72) @(negedge clk);
    vectors++; if (txd !== 1'b0) begin miscompares++; $display("FAIL rst_bit3: got %b want 0", txd); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (txd !== 1'b1)    begin miscompares++; $display("FAIL rst_txd: got %b want 1", txd); end
    vectors++; if (ti !== 1'b1)     begin miscompares++; $display("FAIL rst_idle: got %b want 1", ti); end
    vectors++; if (te !== 1'b1)     begin miscompares++; $display("FAIL rst_txempty: got %b want 1", te); end
    vectors++; if (rcount !== 5'd0) begin miscompares++; $display("FAIL rst_rxcount: got %0d want 0", rcount); end
    loop_en = 1'b1;
    got = 0;
    tx_write(8'h3C); exp_q.push_back(8'h3C);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      readrx = 1'b0;
      if (cr) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL post_rst_extra: got %h want nothing", rxchar);
        end else begin
          e = exp_q.pop_front(); got++;
          if (rxchar !== e) begin miscompares++; $display("FAIL post_rst_char: got %h want %h", rxchar, e); end
        end
        readrx = 1'b1;
      end
    end
    @(negedge clk); readrx = 1'b0;
    vectors++; if (got != 1)       begin miscompares++; $display("FAIL post_rst_count: got %0d want 1", got); end
    vectors++; if (err !== 3'b000) begin miscompares++; $display("FAIL post_rst_err: got %b want 000", err); end
    loop_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; loop_en = 1'b0; rxd_drv = 1'b1; readrx = 1'b0; wtx = 1'b0; clr = 1'b0; txchar = 8'h00;
    rxd_p = 1'b1; readrx_p = 1'b0; wtx_p = 1'b0; clr_p = 1'b0; txchar_p = 8'h00;
    @(negedge clk);
    test_reset;
    test_tx_frame;
    test_loopback;
    test_back_to_back_full;
    test_rx_overrun;
    test_rx_errors;
    test_reset_mid_tx;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
